// File: rtl/glb_4094_pkg.sv
// Shared types and constants for the GLB 4094 shift-register chain writer.
package glb_4094_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    STROBE
  } state_e;

  localparam int GLB_4094_CLK_DIV_MIN   = 3;
  localparam int GLB_4094_WIDTH_DEFAULT = 24;

endpackage

// File: rtl/glb_4094_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles, restarted whenever
// the writer FSM changes state.
module glb_4094_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Reload explicitly on the terminal count so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/glb_4094_writer.sv
// Autonomous MSB-first loader for the GLB 4094 chain with strobe and sticky OE.
// Define GLB_4094_READBACK_EN to capture the chain's serial return into readback.
module glb_4094_writer
  import glb_4094_pkg::*;
#(
  parameter int WIDTH   = GLB_4094_WIDTH_DEFAULT,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] readback,
  output logic             out_4094_clk,
  output logic             out_4094_data,
  output logic             out_4094_strobe,
  output logic             out_4094_oe,
  input  logic             in_4094_miso
);

  localparam int BW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             strobe_q, strobe_d;
  logic             oe_q, oe_d;
  logic             tick;
  logic             state_change;
  logic             enter_high;
  logic             strobe_exit;

  glb_4094_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state_change),
    .tick (tick)
  );

  assign state_change = (state_d != state_q);
  assign enter_high   = (state_q == LOW) && (state_d == HIGH);
  assign strobe_exit  = (state_q == STROBE) && (state_d == IDLE);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          state_d   = LOW;
          shift_d   = data;
          bit_cnt_d = BW'(WIDTH);
        end
      end
      LOW: begin
        if (tick) begin
          state_d = HIGH;
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
      end
      HIGH: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          state_d   = (bit_cnt_q == BW'(1)) ? STROBE : LOW;
        end
      end
      STROBE: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial data is re-registered only on entry to LOW, so it is already stable
  // a full half-period before SCLK rises and holds through the high phase.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = strobe_exit;
    sclk_d   = (state_d == HIGH);
    strobe_d = (state_d == STROBE);
    oe_d     = oe_q | strobe_exit;
    sdo_d    = 1'b0;
    if (state_d == LOW) begin
      sdo_d = shift_d[WIDTH-1];
    end else if (state_d == HIGH) begin
      sdo_d = sdo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      strobe_q  <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      strobe_q  <= strobe_d;
      oe_q      <= oe_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign out_4094_clk    = sclk_q;
  assign out_4094_data   = sdo_q;
  assign out_4094_strobe = strobe_q;
  assign out_4094_oe     = oe_q;

`ifdef GLB_4094_READBACK_EN
  logic [1:0]       miso_sync_q, miso_sync_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] readback_q, readback_d;

  // MISO is sampled at each SCLK rise, so the chain returns the word latched
  // before this transfer, MSB first.
  always_comb begin
    miso_sync_d = {miso_sync_q[0], in_4094_miso};
    shadow_d    = shadow_q;
    readback_d  = readback_q;
    if (enter_high) begin
      shadow_d = {shadow_q[WIDTH-2:0], miso_sync_q[1]};
    end
    if (strobe_exit) begin
      readback_d = shadow_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_sync_q <= '0;
      shadow_q    <= '0;
      readback_q  <= '0;
    end else begin
      miso_sync_q <= miso_sync_d;
      shadow_q    <= shadow_d;
      readback_q  <= readback_d;
    end
  end

  assign readback = readback_q;
`else
  logic unused_miso;
  assign unused_miso = in_4094_miso;
  assign readback    = '0;
`endif

endmodule

// File: tb/tb_glb_4094_writer.sv
// Scoreboard bench for glb_4094_writer: a 24-bit/CLK_DIV=4 instance with a
// modelled 4094 chain, plus an 8-bit/CLK_DIV=3 instance for edge parameters.
module tb_glb_4094_writer;

  localparam int OBS_BUDGET = 400;

  logic        clk;
  logic        reset;
  logic        start, start_e;
  logic [23:0] data;
  logic [7:0]  data_e;
  logic        busy, done, out_clk, out_data, out_strobe, out_oe, miso;
  logic [23:0] readback;
  logic        busy_e, done_e, out_clk_e, out_data_e, out_strobe_e, out_oe_e, miso_e;
  logic [7:0]  readback_e;
  logic [23:0] chain;

  int checks;
  int failures;

  logic [31:0] exp_word_q[$];
  logic [31:0] exp_rb_q[$];

  int          obs_busy1, obs_first_rise, obs_rises, obs_strobe_cyc;
  int          obs_done_cyc, obs_done_cnt;
  int          hi_min, hi_max, lo_min, lo_max;
  logic        obs_oe_before, obs_oe_done, obs_busy_done;
  logic [31:0] obs_bits, obs_rb;
  bit          obs_timeout;

  glb_4094_writer #(
    .WIDTH  (24),
    .CLK_DIV(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .data           (data),
    .busy           (busy),
    .done           (done),
    .readback       (readback),
    .out_4094_clk   (out_clk),
    .out_4094_data  (out_data),
    .out_4094_strobe(out_strobe),
    .out_4094_oe    (out_oe),
    .in_4094_miso   (miso)
  );

  glb_4094_writer #(
    .WIDTH  (8),
    .CLK_DIV(3)
  ) dut_e (
    .clk            (clk),
    .reset          (reset),
    .start          (start_e),
    .data           (data_e),
    .busy           (busy_e),
    .done           (done_e),
    .readback       (readback_e),
    .out_4094_clk   (out_clk_e),
    .out_4094_data  (out_data_e),
    .out_4094_strobe(out_strobe_e),
    .out_4094_oe    (out_oe_e),
    .in_4094_miso   (miso_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The 4094 chain: shifts on SCLK rise, serial output is its last stage.
  always @(posedge out_clk) chain = {chain[22:0], out_data};
  assign miso   = chain[23];
  assign miso_e = 1'b0;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic launch(input bit sel, input logic [31:0] word);
    logic [31:0] rb;
    rb = 32'h0;
`ifdef GLB_4094_READBACK_EN
    if (!sel) rb = {8'h00, chain};
`endif
    exp_word_q.push_back(word);
    exp_rb_q.push_back(rb);
    if (sel) begin
      start_e = 1'b1;
      data_e  = word[7:0];
    end else begin
      start = 1'b1;
      data  = word[23:0];
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    start_e = 1'b0;
    data    = 24'($urandom());
    data_e  = 8'($urandom());
  endtask

  // Samples one DUT on each falling edge; cycle 1 is the cycle after the accept edge.
  task automatic observe(input bit sel, input int extra, input int poke_cyc,
                         input logic [31:0] poke_data);
    logic sclk, p_sclk, sdo, stb, dn, bsy, oe;
    logic [31:0] rb;
    int c, hi_run, lo_run;
    obs_busy1 = -1; obs_first_rise = -1; obs_rises = 0; obs_strobe_cyc = 0;
    obs_done_cyc = -1; obs_done_cnt = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    obs_oe_before = 1'b0; obs_oe_done = 1'b0; obs_busy_done = 1'b1;
    obs_bits = 32'h0; obs_rb = 32'h0;
    p_sclk = 1'b0; hi_run = 0; lo_run = 0; c = 0;
    while (c < OBS_BUDGET && (obs_done_cyc < 0 || c < obs_done_cyc + extra)) begin
      @(negedge clk);
      c++;
      if (poke_cyc > 0 && c == poke_cyc) begin
        start = 1'b1;
        data  = poke_data[23:0];
      end else if (poke_cyc > 0 && c == poke_cyc + 1) begin
        start = 1'b0;
      end
      sclk = sel ? out_clk_e    : out_clk;
      sdo  = sel ? out_data_e   : out_data;
      stb  = sel ? out_strobe_e : out_strobe;
      dn   = sel ? done_e       : done;
      bsy  = sel ? busy_e       : busy;
      oe   = sel ? out_oe_e     : out_oe;
      rb   = sel ? {24'h0, readback_e} : {8'h0, readback};
      if (c == 1) obs_busy1 = int'(bsy);
      if (sclk && !p_sclk) begin
        obs_rises++;
        if (obs_first_rise < 0) obs_first_rise = c;
        obs_bits = {obs_bits[30:0], sdo};
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
        lo_run = 0;
      end
      if (!sclk && p_sclk) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      if (sclk) hi_run++;
      else lo_run++;
      if (stb) obs_strobe_cyc++;
      if (dn) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc  = c;
          obs_rb        = rb;
          obs_oe_done   = oe;
          obs_busy_done = bsy;
        end
      end
      if (obs_done_cyc < 0) obs_oe_before = oe;
      p_sclk = sclk;
    end
    obs_timeout = (obs_done_cyc < 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start_e = 1'b0; data = '0; data_e = '0;
    chain = 24'h0;
    #2;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (readback !== 24'h0) begin failures++; $display("[TB] FAIL reset_readback: got %h expected 000000", readback); end
    checks++; if (out_clk !== 1'b0) begin failures++; $display("[TB] FAIL reset_sclk: got %b expected 0", out_clk); end
    checks++; if (out_data !== 1'b0) begin failures++; $display("[TB] FAIL reset_sdo: got %b expected 0", out_data); end
    checks++; if (out_strobe !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobe: got %b expected 0", out_strobe); end
    checks++; if (out_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_oe: got %b expected 0", out_oe); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || busy_e !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy: got %b/%b expected 0/0", busy, busy_e); end
  endtask

  task automatic test_basic_load();
    logic [31:0] w, r;
    @(negedge clk);
    launch(1'b0, 32'h00A5C3F0);
    observe(1'b0, 0, 0, 32'h0);
    checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL basic_timeout: no done within %0d cycles", OBS_BUDGET); end
    checks++; if (obs_busy1 != 1) begin failures++; $display("[TB] FAIL basic_busy_c1: got %0d expected 1", obs_busy1); end
    checks++; if (obs_first_rise != 5) begin failures++; $display("[TB] FAIL basic_first_rise: got %0d expected 5", obs_first_rise); end
    checks++; if (obs_rises != 24) begin failures++; $display("[TB] FAIL basic_rises: got %0d expected 24", obs_rises); end
    checks++; if (obs_strobe_cyc != 4) begin failures++; $display("[TB] FAIL basic_strobe_width: got %0d expected 4", obs_strobe_cyc); end
    checks++; if (obs_done_cyc != 197) begin failures++; $display("[TB] FAIL basic_done_cycle: got %0d expected 197", obs_done_cyc); end
    checks++; if (obs_oe_before !== 1'b0 || obs_oe_done !== 1'b1) begin failures++; $display("[TB] FAIL basic_oe_rise: got %b->%b expected 0->1", obs_oe_before, obs_oe_done); end
    checks++; if (chain !== 24'hA5C3F0) begin failures++; $display("[TB] FAIL basic_chain: got %h expected a5c3f0", chain); end
    if (exp_word_q.size() == 0) begin
      checks++; failures++; $display("[TB] FAIL basic_scoreboard: got empty queue expected one entry");
    end else begin
      w = exp_word_q.pop_front(); r = exp_rb_q.pop_front();
      checks++; if (obs_bits !== w) begin failures++; $display("[TB] FAIL basic_bits: got %h expected %h", obs_bits, w); end
      checks++; if (obs_rb !== r) begin failures++; $display("[TB] FAIL basic_readback: got %h expected %h", obs_rb, r); end
    end
  endtask

  task automatic test_readback();
    logic [31:0] w, r;
    @(negedge clk);
    chain = 24'h123456;
    launch(1'b0, 32'h00654321);
    observe(1'b0, 0, 0, 32'h0);
    checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL rb_timeout: no done within %0d cycles", OBS_BUDGET); end
`ifdef GLB_4094_READBACK_EN
    checks++; if (obs_rb !== 32'h00123456) begin failures++; $display("[TB] FAIL rb_value: got %h expected 00123456", obs_rb); end
`else
    checks++; if (obs_rb !== 32'h0) begin failures++; $display("[TB] FAIL rb_value: got %h expected 00000000", obs_rb); end
`endif
    checks++; if (chain !== 24'h654321) begin failures++; $display("[TB] FAIL rb_chain: got %h expected 654321", chain); end
    if (exp_word_q.size() == 0) begin
      checks++; failures++; $display("[TB] FAIL rb_scoreboard: got empty queue expected one entry");
    end else begin
      w = exp_word_q.pop_front(); r = exp_rb_q.pop_front();
      checks++; if (obs_bits !== w) begin failures++; $display("[TB] FAIL rb_bits: got %h expected %h", obs_bits, w); end
      checks++; if (obs_rb !== r) begin failures++; $display("[TB] FAIL rb_scoreboard_rb: got %h expected %h", obs_rb, r); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] w, r;
    @(negedge clk);
    launch(1'b0, 32'h003C3C3C);
    observe(1'b0, 30, 50, 32'h00FFFFFF);
    checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL busy_timeout: no done within %0d cycles", OBS_BUDGET); end
    checks++; if (obs_done_cnt != 1) begin failures++; $display("[TB] FAIL busy_done_count: got %0d expected 1", obs_done_cnt); end
    checks++; if (obs_rises != 24) begin failures++; $display("[TB] FAIL busy_rises: got %0d expected 24", obs_rises); end
    checks++; if (obs_done_cyc != 197) begin failures++; $display("[TB] FAIL busy_done_cycle: got %0d expected 197", obs_done_cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_after: got %b expected 0", busy); end
    if (exp_word_q.size() == 0) begin
      checks++; failures++; $display("[TB] FAIL busy_scoreboard: got empty queue expected one entry");
    end else begin
      w = exp_word_q.pop_front(); r = exp_rb_q.pop_front();
      checks++; if (obs_bits !== w) begin failures++; $display("[TB] FAIL busy_bits: got %h expected %h", obs_bits, w); end
      checks++; if (obs_rb !== r) begin failures++; $display("[TB] FAIL busy_readback: got %h expected %h", obs_rb, r); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, r;
    @(negedge clk);
    launch(1'b0, 32'h00F0F0F0);
    observe(1'b0, 0, 0, 32'h0);
    checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL b2b_timeout1: no done within %0d cycles", OBS_BUDGET); end
    checks++; if (obs_busy_done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_at_done: got %b expected 0", obs_busy_done); end
    if (exp_word_q.size() == 0) begin
      checks++; failures++; $display("[TB] FAIL b2b_scoreboard1: got empty queue expected one entry");
    end else begin
      w = exp_word_q.pop_front(); r = exp_rb_q.pop_front();
      checks++; if (obs_bits !== w) begin failures++; $display("[TB] FAIL b2b_bits1: got %h expected %h", obs_bits, w); end
      checks++; if (obs_rb !== r) begin failures++; $display("[TB] FAIL b2b_readback1: got %h expected %h", obs_rb, r); end
    end
    launch(1'b0, 32'h00000001);
    observe(1'b0, 0, 0, 32'h0);
    checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL b2b_timeout2: no done within %0d cycles", OBS_BUDGET); end
    checks++; if (obs_busy1 != 1) begin failures++; $display("[TB] FAIL b2b_busy_c1: got %0d expected 1", obs_busy1); end
    checks++; if (obs_done_cyc != 197) begin failures++; $display("[TB] FAIL b2b_done_cycle: got %0d expected 197", obs_done_cyc); end
    checks++; if (obs_bits[0] !== 1'b1) begin failures++; $display("[TB] FAIL b2b_last_bit: got %b expected 1", obs_bits[0]); end
    if (exp_word_q.size() == 0) begin
      checks++; failures++; $display("[TB] FAIL b2b_scoreboard2: got empty queue expected one entry");
    end else begin
      w = exp_word_q.pop_front(); r = exp_rb_q.pop_front();
      checks++; if (obs_bits !== w) begin failures++; $display("[TB] FAIL b2b_bits2: got %h expected %h", obs_bits, w); end
      checks++; if (obs_rb !== r) begin failures++; $display("[TB] FAIL b2b_readback2: got %h expected %h", obs_rb, r); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, r;
    logic seen_done;
    @(negedge clk);
    launch(1'b0, 32'h00C33C5A);
    repeat (60) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_clk !== 1'b0 || out_data !== 1'b0 || out_strobe !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_pins: got clk=%b data=%b strobe=%b expected 0/0/0", out_clk, out_data, out_strobe);
    end
    checks++; if (out_oe !== 1'b0) begin failures++; $display("[TB] FAIL mid_oe: got %b expected 0", out_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    exp_word_q.delete();
    exp_rb_q.delete();
    seen_done = 1'b0;
    repeat (3) begin @(negedge clk); seen_done = seen_done | done; end
    reset = 1'b0;
    repeat (20) begin @(negedge clk); seen_done = seen_done | done; end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_done: got %b expected 0", seen_done); end
    @(negedge clk);
    launch(1'b0, 32'h005A5A5A);
    observe(1'b0, 0, 0, 32'h0);
    checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL mid_timeout: no done within %0d cycles", OBS_BUDGET); end
    checks++; if (obs_first_rise != 5) begin failures++; $display("[TB] FAIL mid_first_rise: got %0d expected 5", obs_first_rise); end
    checks++; if (obs_done_cyc != 197) begin failures++; $display("[TB] FAIL mid_done_cycle: got %0d expected 197", obs_done_cyc); end
    checks++; if (obs_oe_before !== 1'b0 || obs_oe_done !== 1'b1) begin failures++; $display("[TB] FAIL mid_oe_rise: got %b->%b expected 0->1", obs_oe_before, obs_oe_done); end
    if (exp_word_q.size() == 0) begin
      checks++; failures++; $display("[TB] FAIL mid_scoreboard: got empty queue expected one entry");
    end else begin
      w = exp_word_q.pop_front(); r = exp_rb_q.pop_front();
      checks++; if (obs_bits !== w) begin failures++; $display("[TB] FAIL mid_bits: got %h expected %h", obs_bits, w); end
      checks++; if (obs_rb !== r) begin failures++; $display("[TB] FAIL mid_readback: got %h expected %h", obs_rb, r); end
    end
  endtask

  task automatic test_edge_params();
    logic [31:0] w, r;
    @(negedge clk);
    launch(1'b1, 32'h00000081);
    observe(1'b1, 0, 0, 32'h0);
    checks++; if (obs_timeout) begin failures++; $display("[TB] FAIL edge_timeout: no done within %0d cycles", OBS_BUDGET); end
    checks++; if (obs_done_cyc != 52) begin failures++; $display("[TB] FAIL edge_done_cycle: got %0d expected 52", obs_done_cyc); end
    checks++; if (obs_rises != 8) begin failures++; $display("[TB] FAIL edge_rises: got %0d expected 8", obs_rises); end
    checks++; if (hi_min != 3 || hi_max != 3) begin failures++; $display("[TB] FAIL edge_sclk_high: got %0d..%0d expected 3..3", hi_min, hi_max); end
    checks++; if (lo_min != 3 || lo_max != 3) begin failures++; $display("[TB] FAIL edge_sclk_low: got %0d..%0d expected 3..3", lo_min, lo_max); end
    checks++; if (obs_strobe_cyc != 3) begin failures++; $display("[TB] FAIL edge_strobe_width: got %0d expected 3", obs_strobe_cyc); end
    if (exp_word_q.size() == 0) begin
      checks++; failures++; $display("[TB] FAIL edge_scoreboard: got empty queue expected one entry");
    end else begin
      w = exp_word_q.pop_front(); r = exp_rb_q.pop_front();
      checks++; if (obs_bits !== w) begin failures++; $display("[TB] FAIL edge_bits: got %h expected %h", obs_bits, w); end
      checks++; if (obs_rb !== r) begin failures++; $display("[TB] FAIL edge_readback: got %h expected %h", obs_rb, r); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_load();
    test_readback();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_edge_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
